// File: rtl/fp_op_scheduler.sv
// Round-robin scheduler sharing one FP add/mul datapath between requesters A and B:
// latches operands, pulses start, waits for done under a watchdog and returns the result.
module fp_op_scheduler #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_op,
  input  logic [31:0] a_x,
  input  logic [31:0] a_y,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_op,
  input  logic [31:0] b_x,
  input  logic [31:0] b_y,
  output logic        fpu_start,
  output logic        fpu_op,
  output logic [31:0] fpu_x,
  output logic [31:0] fpu_y,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t           state_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [15:0]      op_count_q;
  logic [15:0]      op_count_d;
  logic             fpu_start_q;
  logic             fpu_op_q;
  logic [31:0]      fpu_x_q;
  logic [31:0]      fpu_y_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic [31:0]      resp_data_q;
  logic             resp_err_q;
  logic             grant_a;
  logic             grant_b;

  // last_grant_q==1 means B was served last, so A wins a tie.
  assign grant_a = a_valid && (!b_valid || last_grant_q);
  assign grant_b = b_valid && !grant_a;
  assign a_ready = (state_q == IDLE) && grant_a;
  assign b_ready = (state_q == IDLE) && grant_b;

  assign cnt_d      = cnt_q + 1'b1;
  assign op_count_d = op_count_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      op_count_q   <= '0;
      fpu_start_q  <= 1'b0;
      fpu_op_q     <= 1'b0;
      fpu_x_q      <= '0;
      fpu_y_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (a_ready || b_ready) begin
            fpu_op_q     <= b_ready ? b_op : a_op;
            fpu_x_q      <= b_ready ? b_x  : a_x;
            fpu_y_q      <= b_ready ? b_y  : a_y;
            resp_id_q    <= b_ready;
            last_grant_q <= b_ready;
            fpu_start_q  <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          fpu_start_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_d;
          // A done landing on the last watchdog cycle still counts as success.
          if (fpu_done) begin
            resp_data_q  <= fpu_result;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            resp_data_q  <= QNAN;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            op_count_q   <= op_count_d;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fpu_start  = fpu_start_q;
  assign fpu_op     = fpu_op_q;
  assign fpu_x      = fpu_x_q;
  assign fpu_y      = fpu_y_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign op_count   = op_count_q;

endmodule
